inv_key_sched: RTL and testbench
================================

// Module: inv_key_sched
// PURPOSE
//  Iterative AES-128 inverse key schedule: takes the final round key and walks back one round per
//  handshake, emitting round keys NR..0 in decrypt order. Sits beside the decrypt datapath as the
//  reverse counterpart of key_gen; reuses the existing sbox. Bit order [0:127] big-endian, column-wise.
// PARAMETERS
//  NR  10  number of rounds; legal range 1..10, bounded by the Rcon table
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    asynchronous, active-high reset
//  start     in   1    load last_key and begin; accepted only in IDLE
//  last_key  in   128  round-NR key [0:127], sampled on the start cycle
//  rk        out  128  current round key [0:127]
//  rk_round  out  4    round index of rk (NR..0)
//  rk_valid  out  1    rk/rk_round valid
//  rk_ready  in   1    consumer accepts rk when rk_valid & rk_ready
//  busy      out  1    high from start acceptance through the final handshake
//  done      out  1    one-cycle pulse on the cycle after round-0 handshake
// BEHAVIOUR
//  Reset (async): state=IDLE, key_reg=0, cnt=0; rk=0, rk_round=0, rk_valid=0, busy=0, done=0.
//  FSM IDLE -> RUN on start. RUN -> DONE on handshake when cnt==0. DONE -> IDLE unconditionally.
//  IDLE: start=1 -> key_reg<=last_key, cnt<=NR. rk_valid, busy rise the next cycle (latency 1).
//  RUN: rk_valid=1, rk=key_reg, rk_round=cnt, busy=1. Registered outputs, no comb path from rk_ready.
//   Handshake, cnt>0: key_reg<=inv_step(key_reg, rcon[cnt]), cnt<=cnt-1.
//   Handshake, cnt==0: rk_valid<=0, busy<=0; go DONE.
//   No handshake: rk, rk_round, key_reg held stable. Stall is unbounded.
//  DONE: done=1 for exactly one cycle; start ignored; then IDLE.
//  start while RUN or DONE: ignored, no reload, no error.
//  Throughput: rk_ready held high -> NR+1 keys on consecutive cycles; total start-to-done = NR+3 cycles.
//  inv_step(w0..w3 32-bit words, rc):
//   p3=w3^w2; p2=w2^w1; p1=w1^w0;
//   p0=w0^SubWord(RotWord(p3))^{rc,24'h0}.
//   RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0).
//   SubWord = 4 sbox instances, high/low nibble inputs.
//  rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Index = cnt of the key being stepped from.
//  Reset mid-operation: immediate abort to IDLE. No done pulse. Outputs take reset values.
//  All XOR is bitwise, width-exact. No carries or truncation. cnt is 4 bits; never wraps below 0.
// STRUCTURE
//  Shared package aes_pkg:
//   rcon function or table (8-bit, indices 1..10);
//   FSM state constants IDLE/RUN/DONE (2-bit);
//   word-slice helper constants.
//  Sub-module inv_key_step (combinational):
//   in key[0:127], rc[0:7]; out prev_key[0:127];
//   instantiates 4 x sbox.
//  Top holds FSM, key_reg, cnt, output registers only.
// TESTING
//  FIPS-197 A.1, ready=1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start 1 cycle ->
//   round10 = d014f9a8c9ee2589e13f0cc8b6630ca6, next round9 = ac7766f319fadc2128d12941575c006e,
//   round1 = a0fafe1788542cb123a339392a6c7605, round0 = 2b7e151628aed2a6abf7158809cf4f3c;
//   done pulses 1 cycle after round 0 handshake.
//  Backpressure: drop rk_ready for 5 cycles at round 6 ->
//   rk, rk_round=6 held stable; sequence resumes, identical to ready=1 run.
//  start pulsed while busy (at round 4) -> ignored; remaining keys and done unchanged.
//  rst asserted async mid-run (round 3) -> rk_valid=0, busy=0, rk=0 same cycle, no done;
//   fresh start afterward yields full correct sequence.
//  Back-to-back: second start on the DONE cycle ignored; start the following cycle accepted;
//   rk_round restarts at NR=10.
//  Parameter NR=1: last_key=a0fafe1788542cb123a339392a6c7605 ->
//   exactly two keys (round1, round0=2b7e1516...4f3c), then done.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : aes_pkg                                                         |
// | Purpose  : Shared AES key-schedule definitions: FSM states, round-constant |
// |            lookup and 128-bit key word-slice helpers.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Key words are numbered 0..3 from the most significant end, so word 0
   // sits in bits [127:96].
   localparam int C_WORD_W  = 32;
   localparam int C_NUM_WRD = 4;

   function automatic logic [31:0] key_word(input logic [127:0] key, input int idx);
      return key[127 - C_WORD_W*idx -: C_WORD_W];
   endfunction

   // Round constant for rounds 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inv_key_step                                                    |
// | Purpose  : One backward step of the AES-128 key schedule (combinational).  |
// | Ports    : key      (128) - round-n key, word 0 in the MSBs               |
// |            rc       (8)   - Rcon of round n                                |
// |            prev_key (128) - round n-1 key                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module inv_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [7:0]   rc,
   output logic [127:0] prev_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p0, p1, p2, p3;
   logic [31:0] rot_w;
   logic [31:0] sub_w;

   assign w0 = key_word(key, 0);
   assign w1 = key_word(key, 1);
   assign w2 = key_word(key, 2);
   assign w3 = key_word(key, 3);

   // Words 1..3 of the previous key fall straight out of the forward XOR chain;
   // word 3 is needed first because word 0 depends on it.
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

   assign rot_w = {p3[23:0], p3[31:24]};

   for (genvar i = 0; i < C_NUM_WRD; i++) begin : g_sbox
      sbox u_sbox (
         .in_byte  (rot_w[8*i +: 8]),
         .out_byte (sub_w[8*i +: 8])
      );
   end

   assign p0       = w0 ^ sub_w ^ {rc, 24'h000000};
   assign prev_key = {p0, p1, p2, p3};

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sbox                                                            |
// | Purpose  : AES forward S-box, purely combinational.                        |
// | Ports    : in_byte  (8) - input byte                                       |
// |            out_byte (8) - substituted byte                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign out_byte = affine(gf_inv(in_byte));

endmodule
`default_nettype wire

// File: rtl/inv_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inv_key_sched                                                   |
// | Purpose  : Iterative AES-128 inverse key schedule. Loads the last round    |
// |            key and emits round keys NR..0, one per valid/ready handshake.  |
// | Ports    : clk, rst (async, active high)                                   |
// |            start, last_key[127:0]          - load and begin (IDLE only)    |
// |            rk[127:0], rk_round[3:0],        - current key and its round     |
// |            rk_valid / rk_ready              - output handshake              |
// |            busy, done                       - status, done is a 1-cycle    |
// |                                               pulse after round 0          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module inv_key_sched
   import aes_pkg::*;
#(
   parameter int NR = 10   // 1..10, limited by the Rcon table
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] last_key,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] C_NR = 4'(NR);

   state_e       state_q, state_d;
   logic [127:0] key_reg_q, key_reg_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] prev_key;

   inv_key_step u_step (
      .key      (key_reg_q),
      .rc       (rcon(cnt_q)),
      .prev_key (prev_key)
   );

   always_comb begin
      state_d   = state_q;
      key_reg_d = key_reg_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_reg_d = last_key;
               cnt_d     = C_NR;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rk_ready) begin
               if (cnt_q != 4'd0) begin
                  key_reg_d = prev_key;
                  cnt_d     = cnt_q - 4'd1;
               end else begin
                  // Round-0 key stays in key_reg; cnt is already 0.
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         key_reg_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         key_reg_q <= key_reg_d;
         cnt_q     <= cnt_d;
      end
   end

   // All outputs decode straight from flops, so rk_ready never reaches them
   // combinationally and they all clear together on an asynchronous reset.
   assign rk       = key_reg_q;
   assign rk_round = cnt_q;
   assign rk_valid = (state_q == ST_RUN);
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_inv_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_inv_key_sched                                                |
// | Purpose  : Self-checking bench for inv_key_sched (NR=10 and NR=1).         |
// |            Expected keys come from a word-level inverse of the FIPS-197    |
// |            key expansion using an S-box table built by the generator walk. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] last_key = '0;
   logic         rk_ready = 1'b0;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_valid, busy, done;

   logic         s1_start = 1'b0;
   logic [127:0] s1_last_key = '0;
   logic         s1_rk_ready = 1'b0;
   logic [127:0] s1_rk;
   logic [3:0]   s1_rk_round;
   logic         s1_rk_valid, s1_busy, s1_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sb  [0:255];
   logic [7:0]   rct [1:10];
   logic [127:0] exp_keys [0:10];
   logic [127:0] obs [0:10];

   inv_key_sched #(.NR(10)) dut (
      .clk(clk), .rst(rst), .start(start), .last_key(last_key),
      .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .busy(busy), .done(done)
   );

   inv_key_sched #(.NR(1)) dut1 (
      .clk(clk), .rst(rst), .start(s1_start), .last_key(s1_last_key),
      .rk(s1_rk), .rk_round(s1_rk_round), .rk_valid(s1_rk_valid), .rk_ready(s1_rk_ready),
      .busy(s1_busy), .done(s1_done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, o, e);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box table via the 3/(3^-1) generator walk over GF(2^8).
   task automatic build_tables;
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      rct[1] = 8'h01;
      for (int i = 2; i <= 10; i++)
         rct[i] = {rct[i-1][6:0], 1'b0} ^ (rct[i-1][7] ? 8'h1b : 8'h00);
   endtask

   // Run the FIPS-197 word recurrence w[i] = w[i-4] ^ temp(w[i-1]) backwards.
   task automatic build_model(input logic [127:0] last, input int nr);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int j = 0; j < 4; j++) w[4*nr + j] = last[127 - 32*j -: 32];
      for (int i = 4*nr + 3; i >= 4; i--) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t = t ^ {rct[i/4], 24'h0};
         end
         w[i-4] = w[i] ^ t;
      end
      for (int r = 0; r <= nr; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full NR=10 transaction starting from IDLE. Negative round numbers
   // disable the corresponding disturbance.
   task automatic run_check(input logic [127:0] key, input int stall_round, input int stall_len,
                            input int pulse_round, input int abort_round, input bit rnd_ready,
                            input bit b2b);
      int  stalls;
      int  cyc;
      bit  rdy;
      build_model(key, 10);
      chk("idle_valid", {127'b0, rk_valid}, 128'd0);
      start = 1'b1;
      last_key = key;
      tick();
      start = 1'b0;
      last_key = rnd128();
      for (int r = 10; r >= 0; r--) begin
         stalls = 0;
         cyc = 0;
         forever begin
            chk($sformatf("rk_r%0d", r), rk, exp_keys[r]);
            chk($sformatf("round_r%0d", r), {124'b0, rk_round}, 128'(r));
            chk($sformatf("valid_busy_r%0d", r), {126'b0, rk_valid, busy}, 128'd3);
            if (r == abort_round) begin
               #3 rst = 1'b1;
               #1;
               chk("abort_rk", rk, 128'd0);
               chk("abort_round", {124'b0, rk_round}, 128'd0);
               chk("abort_flags", {125'b0, rk_valid, busy, done}, 128'd0);
               tick();
               tick();
               chk("abort_no_done", {127'b0, done}, 128'd0);
               rst = 1'b0;
               tick();
               chk("abort_idle", {126'b0, rk_valid, done}, 128'd0);
               return;
            end
            start = (r == pulse_round && cyc == 0);
            if (start) last_key = rnd128();
            if (r == stall_round && stalls < stall_len) begin
               rdy = 1'b0;
               stalls++;
            end else if (rnd_ready && cyc < 20) begin
               rdy = 1'($urandom_range(0, 1));
            end else begin
               rdy = 1'b1;
            end
            rk_ready = rdy;
            obs[r] = rk;
            tick();
            start = 1'b0;
            cyc++;
            if (rdy) break;
         end
      end
      rk_ready = 1'b0;
      chk("done_pulse", {125'b0, done, rk_valid, busy}, 128'd4);
      if (b2b) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_drop", {125'b0, done, rk_valid, busy}, 128'd0);
   endtask

   initial begin
      build_tables();

      // Reset values
      tick();
      tick();
      chk("rst_rk", rk, 128'd0);
      chk("rst_round", {124'b0, rk_round}, 128'd0);
      chk("rst_flags", {125'b0, rk_valid, busy, done}, 128'd0);
      chk("rst_s1_flags", {125'b0, s1_rk_valid, s1_busy, s1_done}, 128'd0);
      rst = 1'b0;
      tick();

      // FIPS-197 A.1 with ready held high
      run_check(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 0, -1, -1, 1'b0, 1'b0);
      chk("fips_r10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("fips_r9",  obs[9],  128'hac7766f319fadc2128d12941575c006e);
      chk("fips_r1",  obs[1],  128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_r0",  obs[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

      // Backpressure: 5 stalled cycles at round 6
      run_check(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 6, 5, -1, -1, 1'b0, 1'b0);
      chk("bp_r0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // start pulsed while busy at round 4
      run_check(rnd128(), -1, 0, 4, -1, 1'b0, 1'b0);

      // Async reset at round 3, then a fresh full run
      run_check(rnd128(), -1, 0, -1, 3, 1'b0, 1'b0);
      run_check(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 0, -1, -1, 1'b0, 1'b0);
      chk("post_rst_r0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // Back-to-back: start on the DONE cycle is ignored, next cycle accepted
      run_check(rnd128(), -1, 0, -1, -1, 1'b0, 1'b1);
      run_check(rnd128(), -1, 0, -1, -1, 1'b0, 1'b0);

      // Random keys with random ready
      for (int n = 0; n < 4; n++) run_check(rnd128(), -1, 0, -1, -1, 1'b1, 1'b0);

      // NR=1 instance
      s1_start = 1'b1;
      s1_last_key = 128'ha0fafe1788542cb123a339392a6c7605;
      s1_rk_ready = 1'b1;
      tick();
      s1_start = 1'b0;
      chk("nr1_rk1", s1_rk, 128'ha0fafe1788542cb123a339392a6c7605);
      chk("nr1_round1", {124'b0, s1_rk_round}, 128'd1);
      chk("nr1_valid1", {126'b0, s1_rk_valid, s1_busy}, 128'd3);
      tick();
      chk("nr1_rk0", s1_rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("nr1_round0", {124'b0, s1_rk_round}, 128'd0);
      chk("nr1_valid0", {126'b0, s1_rk_valid, s1_busy}, 128'd3);
      tick();
      chk("nr1_done", {125'b0, s1_done, s1_rk_valid, s1_busy}, 128'd4);
      tick();
      chk("nr1_idle", {125'b0, s1_done, s1_rk_valid, s1_busy}, 128'd0);
      s1_rk_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
